// File: rtl/vscpu_core_p.sv
// vscpu_core_p: parametrised VerySimpleCPU core with a req/ack memory handshake, retire, halt and illegal strobes.
// Define VSCPU_MUL_EN to implement MUL/MULi (opcodes 14/15); otherwise they retire as illegal no-ops.
module vscpu_core_p #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_fromRAM,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              wrEn,
  output logic [ADDR_W-1:0] addr_toRAM,
  output logic [DATA_W-1:0] data_toRAM,
  output logic [ADDR_W-1:0] pc_o,
  output logic              retire,
  output logic              halted,
  output logic              illegal
);

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_CP   = 4'd8;
  localparam logic [OP_W-1:0] OP_CPI  = 4'd9;
  localparam logic [OP_W-1:0] OP_CPR  = 4'd10;
  localparam logic [OP_W-1:0] OP_CPRI = 4'd11;
  localparam logic [OP_W-1:0] OP_BZJ  = 4'd12;
  localparam logic [OP_W-1:0] OP_BZJI = 4'd13;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd14;
  localparam logic [OP_W-1:0] OP_MULI = 4'd15;

`ifdef VSCPU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_FETCH = 3'd1,
    S_RD_A  = 3'd2,
    S_RD_B  = 3'd3,
    S_RD_I  = 3'd4,
    S_WRITE = 3'd5,
    S_HALT  = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] iw_q, iw_d;
  logic [DATA_W-1:0] r1_q, r1_d;
  logic [DATA_W-1:0] r2_q, r2_d;
  logic [ADDR_W-1:0] wa_q, wa_d;

  logic [OP_W-1:0]   op_q, op_f;
  logic [ADDR_W-1:0] a_fld, b_fld, a_f, b_f, npc, jmp, rd_addr;
  logic [DATA_W-1:0] b_imm;
  logic              retire_c, illegal_c;

  assign op_q    = iw_q[DATA_W-1 -: OP_W];
  assign a_fld   = iw_q[2*ADDR_W-1 -: ADDR_W];
  assign b_fld   = iw_q[ADDR_W-1:0];
  assign b_imm   = DATA_W'(b_fld);
  assign op_f    = data_fromRAM[DATA_W-1 -: OP_W];
  assign a_f     = data_fromRAM[2*ADDR_W-1 -: ADDR_W];
  assign b_f     = data_fromRAM[ADDR_W-1:0];
  assign rd_addr = data_fromRAM[ADDR_W-1:0];
  assign npc     = pc_q + ADDR_W'(1);

  // Two-operand datapath shared by the ALU opcodes; op[0] only selects the operand source.
  function automatic logic [DATA_W-1:0] alu(input logic [OP_W-1:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = '0;
    case (op[3:1])
      3'd0:    r = a + x;
      3'd1:    r = ~(a & x);
      3'd2:    r = (x < DATA_W'(DATA_W)) ? (a >> x) : (a << (x - DATA_W'(DATA_W)));
      3'd3:    r = DATA_W'(a < x);
`ifdef VSCPU_MUL_EN
      3'd7:    r = a * x;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    iw_d      = iw_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    wa_d      = wa_q;
    jmp       = '0;
    retire_c  = 1'b0;
    illegal_c = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: if (mem_ack) begin
        iw_d = data_fromRAM;
        case (op_f)
          OP_CP, OP_CPR: state_d = S_RD_B;
          OP_CPI: begin
            r2_d    = DATA_W'(b_f);
            wa_d    = a_f;
            state_d = S_WRITE;
          end
          OP_MUL, OP_MULI: begin
            if (MUL_EN) begin
              state_d = S_RD_A;
            end else begin
              illegal_c = 1'b1;
              retire_c  = 1'b1;
              pc_d      = npc;
            end
          end
          default: state_d = S_RD_A;
        endcase
      end
      S_RD_A: if (mem_ack) begin
        r1_d = data_fromRAM;
        case (op_q)
          OP_BZJI: begin
            jmp      = rd_addr + b_fld;
            retire_c = 1'b1;
            if (jmp == pc_q) begin
              state_d = S_HALT;
            end else begin
              pc_d    = jmp;
              state_d = S_FETCH;
            end
          end
          OP_CPRI: begin
            wa_d    = rd_addr;
            state_d = S_RD_B;
          end
          OP_BZJ: state_d = S_RD_B;
          default: begin
            if (op_q[0]) begin
              r2_d    = alu(op_q, data_fromRAM, b_imm);
              wa_d    = a_fld;
              state_d = S_WRITE;
            end else begin
              state_d = S_RD_B;
            end
          end
        endcase
      end
      S_RD_B: if (mem_ack) begin
        case (op_q)
          OP_CP: begin
            r2_d    = data_fromRAM;
            wa_d    = a_fld;
            state_d = S_WRITE;
          end
          OP_CPR: begin
            r2_d    = data_fromRAM;
            state_d = S_RD_I;
          end
          // Write address was captured from *A in RD_A.
          OP_CPRI: begin
            r2_d    = data_fromRAM;
            state_d = S_WRITE;
          end
          OP_BZJ: begin
            jmp      = (data_fromRAM == '0) ? r1_q[ADDR_W-1:0] : npc;
            retire_c = 1'b1;
            if (jmp == pc_q) begin
              state_d = S_HALT;
            end else begin
              pc_d    = jmp;
              state_d = S_FETCH;
            end
          end
          default: begin
            r2_d    = alu(op_q, r1_q, data_fromRAM);
            wa_d    = a_fld;
            state_d = S_WRITE;
          end
        endcase
      end
      S_RD_I: if (mem_ack) begin
        r2_d    = data_fromRAM;
        wa_d    = a_fld;
        state_d = S_WRITE;
      end
      S_WRITE: if (mem_ack) begin
        pc_d     = npc;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RESET;
      pc_q    <= '0;
      iw_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      wa_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iw_q    <= iw_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      wa_q    <= wa_d;
    end
  end

  // Bus outputs decode registered state only, so they cannot move while a request waits.
  always_comb begin
    mem_req    = 1'b0;
    wrEn       = 1'b0;
    addr_toRAM = '0;
    data_toRAM = '0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        addr_toRAM = pc_q;
      end
      S_RD_A: begin
        mem_req    = 1'b1;
        addr_toRAM = a_fld;
      end
      S_RD_B: begin
        mem_req    = 1'b1;
        addr_toRAM = b_fld;
      end
      S_RD_I: begin
        mem_req    = 1'b1;
        addr_toRAM = r2_q[ADDR_W-1:0];
      end
      S_WRITE: begin
        mem_req    = 1'b1;
        wrEn       = 1'b1;
        addr_toRAM = wa_q;
        data_toRAM = r2_q;
      end
      default: mem_req = 1'b0;
    endcase
  end

  assign pc_o    = pc_q;
  assign halted  = (state_q == S_HALT);
  assign retire  = retire_c;
  assign illegal = illegal_c;

endmodule

// File: tb/tb_vscpu_core_p.sv
// Bench for vscpu_core_p: wait-state RAM model, write scoreboard, vector table plus hand sequences.
module tb_vscpu_core_p;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 14;
  localparam int unsigned MEM_N = 1 << AW;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_fromRAM;
  logic          mem_ack;
  logic          mem_req;
  logic          wrEn;
  logic [AW-1:0] addr_toRAM;
  logic [DW-1:0] data_toRAM;
  logic [AW-1:0] pc_o;
  logic          retire;
  logic          halted;
  logic          illegal;

  vscpu_core_p #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_fromRAM (data_fromRAM),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .wrEn         (wrEn),
    .addr_toRAM   (addr_toRAM),
    .data_toRAM   (data_toRAM),
    .pc_o         (pc_o),
    .retire       (retire),
    .halted       (halted),
    .illegal      (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [DW-1:0]      mem [0:MEM_N-1];
  logic [AW+DW-1:0]   exp_q[$];
  int n_cmp, n_err;
  int wait_n, wcnt, req_cyc, cyc_at_ret, retire_cnt, illegal_cnt, ill_alone, unstable;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [3:0] op, input logic [AW-1:0] a,
                                       input logic [AW-1:0] b);
    return {op, a, b};
  endfunction

  // RAM model: inserts wait_n wait cycles per access, checks writes against the scoreboard.
  initial begin
    logic [AW+DW:0]   cur, snap;
    logic [AW+DW-1:0] e;
    mem_ack      = 1'b0;
    data_fromRAM = '0;
    snap         = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else if (mem_req) begin
        req_cyc++;
        cur = {wrEn, addr_toRAM, data_toRAM};
        if (wcnt == 0) snap = cur;
        else if (cur !== snap) unstable++;
        if (wcnt < wait_n) begin
          mem_ack = 1'b0;
          wcnt++;
        end else begin
          mem_ack = 1'b1;
          wcnt    = 0;
          if (wrEn) begin
            mem[addr_toRAM] = data_toRAM;
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                       addr_toRAM, data_toRAM);
            end else begin
              e = exp_q.pop_front();
              if (e !== {addr_toRAM, data_toRAM}) begin
                n_err++;
                $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                         addr_toRAM, data_toRAM, e[AW+DW-1:DW], e[DW-1:0]);
              end
            end
          end else begin
            data_fromRAM = mem[addr_toRAM];
          end
        end
      end else begin
        mem_ack = 1'b0;
      end
      #1;
      if (retire) begin
        retire_cnt++;
        cyc_at_ret = req_cyc;
      end
      if (illegal) illegal_cnt++;
      if (illegal && !retire) ill_alone++;
    end
  end

  task automatic setup(input int w);
    rst = 1'b0;
    wait_n = w;
    for (int i = 0; i < int'(MEM_N); i++) mem[i] = '0;
    exp_q.delete();
    req_cyc = 0; cyc_at_ret = 0; retire_cnt = 0; illegal_cnt = 0; ill_alone = 0; unstable = 0;
    @(negedge clk);
  endtask

  task automatic release_rst();
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic run_prog(input string nm, input int n_ret);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (retire_cnt >= n_ret) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    chk({nm, "_done"}, 64'(ok), 64'(1));
  endtask

  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] a, b;
    logic [DW-1:0] va, vb;
    logic [AW-1:0] xa;
    logic [DW-1:0] xv;
    int            w;
    bit            ew;
    logic [AW-1:0] ewa;
    logic [DW-1:0] ewd;
    logic [AW-1:0] epc;
    int            ecyc;
    int            eill;
  } vec_t;

  vec_t vt[$];

  initial begin
    vec_t v;
    n_cmp = 0; n_err = 0;
    wait_n = 0; wcnt = 0; req_cyc = 0; cyc_at_ret = 0;
    retire_cnt = 0; illegal_cnt = 0; ill_alone = 0; unstable = 0;

    // Asynchronous reset with no clock edge: all outputs low.
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("reset_outputs", 64'({mem_req, wrEn, addr_toRAM, data_toRAM, pc_o, retire, halted, illegal}), 64'(0));

    // ADD 100,101 with first-fetch timing.
    setup(0);
    mem[100] = 32'd7; mem[101] = 32'd5; mem[0] = mk(4'd0, 14'd100, 14'd101);
    exp_q.push_back({14'd100, 32'd12});
    release_rst();
    #1 chk("pre_fetch_req", 64'(mem_req), 64'(0));
    @(posedge clk); #1;
    chk("first_fetch", 64'({mem_req, wrEn, addr_toRAM}), 64'({1'b1, 1'b0, 14'd0}));
    run_prog("add", 1);
    chk("add_pc", 64'(pc_o), 64'(1));
    chk("add_cyc", 64'(cyc_at_ret), 64'(4));
    chk("add_wr_done", 64'(exp_q.size()), 64'(0));

    //            op  a       b          va            vb            xa      xv          w  ew ewa     ewd           epc       cyc ill
    vt.push_back('{4'd1, 14'd100, 14'd3,     32'hFFFF_FFFF, 32'd0,        14'd0,  32'd0,      0, 1, 14'd100, 32'd2,        14'd1,    3, 0});
    vt.push_back('{4'd2, 14'd100, 14'd101,   32'hF0F0_F0F0, 32'hFF00_FF00, 14'd0, 32'd0,      0, 1, 14'd100, 32'h0FFF_0FFF, 14'd1,   4, 0});
    vt.push_back('{4'd3, 14'd100, 14'h3FFF,  32'hFFFF_FFFF, 32'd0,        14'd0,  32'd0,      0, 1, 14'd100, 32'hFFFF_C000, 14'd1,   3, 0});
    vt.push_back('{4'd4, 14'd100, 14'd101,   32'h0000_00F0, 32'd36,       14'd0,  32'd0,      0, 1, 14'd100, 32'h0000_0F00, 14'd1,   4, 0});
    vt.push_back('{4'd4, 14'd100, 14'd101,   32'h0000_00F0, 32'd4,        14'd0,  32'd0,      0, 1, 14'd100, 32'h0000_000F, 14'd1,   4, 0});
    vt.push_back('{4'd4, 14'd100, 14'd101,   32'h0000_00F0, 32'd32,       14'd0,  32'd0,      0, 1, 14'd100, 32'h0000_00F0, 14'd1,   4, 0});
    vt.push_back('{4'd5, 14'd100, 14'd64,    32'h0000_00F0, 32'd0,        14'd0,  32'd0,      0, 1, 14'd100, 32'd0,        14'd1,    3, 0});
    vt.push_back('{4'd5, 14'd100, 14'd0,     32'h0000_00F0, 32'd0,        14'd0,  32'd0,      0, 1, 14'd100, 32'h0000_00F0, 14'd1,   3, 0});
    vt.push_back('{4'd6, 14'd100, 14'd101,   32'd3,         32'd5,        14'd0,  32'd0,      0, 1, 14'd100, 32'd1,        14'd1,    4, 0});
    vt.push_back('{4'd6, 14'd100, 14'd101,   32'd5,         32'd5,        14'd0,  32'd0,      0, 1, 14'd100, 32'd0,        14'd1,    4, 0});
    vt.push_back('{4'd7, 14'd100, 14'd4,     32'd3,         32'd0,        14'd0,  32'd0,      0, 1, 14'd100, 32'd1,        14'd1,    3, 0});
    vt.push_back('{4'd8, 14'd100, 14'd101,   32'd0,         32'hDEAD,     14'd0,  32'd0,      0, 1, 14'd100, 32'hDEAD,     14'd1,    3, 0});
    vt.push_back('{4'd9, 14'd100, 14'h1234,  32'd0,         32'd0,        14'd0,  32'd0,      0, 1, 14'd100, 32'h1234,     14'd1,    2, 0});
    vt.push_back('{4'd10, 14'd100, 14'd101,  32'd0,         32'd200,      14'd200, 32'h55AA,  0, 1, 14'd100, 32'h55AA,     14'd1,    4, 0});
    vt.push_back('{4'd11, 14'd50, 14'd51,    32'd60,        32'hABCD,     14'd0,  32'd0,      0, 1, 14'd60,  32'hABCD,     14'd1,    4, 0});
    vt.push_back('{4'd12, 14'd100, 14'd101,  32'h20,        32'd0,        14'd0,  32'd0,      0, 0, 14'd0,   32'd0,        14'h20,   3, 0});
    vt.push_back('{4'd12, 14'd100, 14'd101,  32'h20,        32'd5,        14'd0,  32'd0,      0, 0, 14'd0,   32'd0,        14'd1,    3, 0});
    vt.push_back('{4'd12, 14'd100, 14'd101,  32'hFFFF_0025, 32'd0,        14'd0,  32'd0,      0, 0, 14'd0,   32'd0,        14'h25,   3, 0});
    vt.push_back('{4'd13, 14'd100, 14'd5,    32'd10,        32'd0,        14'd0,  32'd0,      0, 0, 14'd0,   32'd0,        14'd15,   2, 0});
    vt.push_back('{4'd13, 14'd100, 14'h3FFF, 32'd2,         32'd0,        14'd0,  32'd0,      0, 0, 14'd0,   32'd0,        14'd1,    2, 0});
    vt.push_back('{4'd0, 14'd100, 14'd101,   32'd7,         32'd5,        14'd0,  32'd0,      2, 1, 14'd100, 32'd12,       14'd1,   12, 0});
    vt.push_back('{4'd9, 14'd100, 14'd77,    32'd0,         32'd0,        14'd0,  32'd0,      1, 1, 14'd100, 32'd77,       14'd1,    4, 0});
`ifdef VSCPU_MUL_EN
    vt.push_back('{4'd14, 14'd100, 14'd101,  32'd6,         32'd7,        14'd0,  32'd0,      0, 1, 14'd100, 32'd42,       14'd1,    4, 0});
    vt.push_back('{4'd15, 14'd100, 14'd5,    32'd6,         32'd0,        14'd0,  32'd0,      0, 1, 14'd100, 32'd30,       14'd1,    3, 0});
`else
    vt.push_back('{4'd14, 14'd100, 14'd101,  32'd6,         32'd7,        14'd0,  32'd0,      0, 0, 14'd0,   32'd0,        14'd1,    1, 1});
    vt.push_back('{4'd15, 14'd100, 14'd5,    32'd6,         32'd0,        14'd0,  32'd0,      0, 0, 14'd0,   32'd0,        14'd1,    1, 1});
`endif

    foreach (vt[i]) begin
      v = vt[i];
      setup(v.w);
      mem[v.a] = v.va; mem[v.b] = v.vb; mem[v.xa] = v.xv;
      mem[0] = mk(v.op, v.a, v.b);
      if (v.ew) exp_q.push_back({v.ewa, v.ewd});
      release_rst();
      run_prog($sformatf("v%0d", i), 1);
      chk($sformatf("v%0d_pc", i), 64'(pc_o), 64'(v.epc));
      chk($sformatf("v%0d_cyc", i), 64'(cyc_at_ret), 64'(v.ecyc));
      chk($sformatf("v%0d_illegal", i), 64'(illegal_cnt), 64'(v.eill));
      chk($sformatf("v%0d_wr_done", i), 64'(exp_q.size()), 64'(0));
    end

    // ADDi with three wait cycles per access: bus held stable, 12 cycles total.
    setup(3);
    mem[100] = 32'd10; mem[0] = mk(4'd1, 14'd100, 14'd3);
    exp_q.push_back({14'd100, 32'd13});
    release_rst();
    run_prog("wait_addi", 1);
    chk("wait_addi_cyc", 64'(cyc_at_ret), 64'(12));
    chk("wait_addi_stable", 64'(unstable), 64'(0));
    chk("wait_addi_mem", 64'(mem[100]), 64'(13));
    chk("wait_addi_pc", 64'(pc_o), 64'(1));

    // BZJi to 9, then BZJi at 9 targeting itself halts.
    setup(0);
    mem[100] = 32'd9; mem[0] = mk(4'd13, 14'd100, 14'd0); mem[9] = mk(4'd13, 14'd100, 14'd0);
    release_rst();
    run_prog("halt", 2);
    chk("halt_flag", 64'(halted), 64'(1));
    chk("halt_pc", 64'(pc_o), 64'(9));
    req_cyc = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("halt_no_req", 64'({mem_req, 32'(req_cyc)}), 64'(0));
    chk("halt_sticky", 64'({halted, 32'(retire_cnt)}), 64'({1'b1, 32'd2}));

    // Reset asserted while a write waits: outputs clear at once, write abandoned.
    setup(5);
    mem[100] = 32'd7; mem[101] = 32'd5; mem[0] = mk(4'd0, 14'd100, 14'd101);
    release_rst();
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #1;
        if (wrEn) begin
          seen = 1'b1;
          break;
        end
      end
      chk("midrst_write_seen", 64'(seen), 64'(1));
    end
    #2 rst = 1'b0;
    #1;
    chk("midrst_outputs", 64'({mem_req, wrEn, addr_toRAM, data_toRAM, pc_o, retire, halted, illegal}), 64'(0));
    repeat (3) @(posedge clk);
    #1 chk("midrst_mem", 64'(mem[100]), 64'(7));

    // Three CPi then MUL at pc 3.
    setup(0);
    mem[100] = 32'd6; mem[101] = 32'd7;
    mem[0] = mk(4'd9, 14'd300, 14'd1);
    mem[1] = mk(4'd9, 14'd301, 14'd2);
    mem[2] = mk(4'd9, 14'd302, 14'd3);
    mem[3] = mk(4'd14, 14'd100, 14'd101);
    exp_q.push_back({14'd300, 32'd1});
    exp_q.push_back({14'd301, 32'd2});
    exp_q.push_back({14'd302, 32'd3});
`ifdef VSCPU_MUL_EN
    exp_q.push_back({14'd100, 32'd42});
`endif
    release_rst();
    run_prog("mul_pc3", 4);
    chk("mul_pc3_pc", 64'(pc_o), 64'(4));
`ifdef VSCPU_MUL_EN
    chk("mul_pc3_illegal", 64'(illegal_cnt), 64'(0));
`else
    chk("mul_pc3_illegal", 64'(illegal_cnt), 64'(1));
`endif
    chk("mul_pc3_ill_with_retire", 64'(ill_alone), 64'(0));
    chk("mul_pc3_wr_done", 64'(exp_q.size()), 64'(0));

    rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
